// File: rtl/tag_req_arbiter.sv
// Merges AXI AR/AW address requests into one tag-lookup stream through a single registered slot (1-cycle latency).
// Readies drop while the slot is held or the tag FIFO is almost full; round-robin, or read priority under TAG_ARB_RD_PRIO_EN.
module tag_req_arbiter #(
    parameter int ID_W       = 16,
    parameter int ADDR_W     = 64,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   arid_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    input  logic [ID_W-1:0]   awid_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    output logic [ID_W-1:0]   req_id_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic              req_wr_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    input  logic              tag_fifo_afull_i
);

    if (MAX_CONSEC < 1) begin : g_bad_max_consec
        $error("MAX_CONSEC must be at least 1");
    end

    logic              req_valid_q, req_valid_d;
    logic              req_wr_q, req_wr_d;
    logic [ID_W-1:0]   req_id_q, req_id_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              last_wr_q, last_wr_d;

    logic can_accept;
    logic tie_rd;
    logic grant_rd, grant_wr;
    logic hs_rd, hs_wr;

`ifdef TAG_ARB_RD_PRIO_EN
    localparam int CNT_W = $clog2(MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);

    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    // Reads win ties until MAX_CONSEC of them have passed a waiting write.
    assign tie_rd = (rd_cnt_q != CNT_MAX);

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (hs_wr) begin
            rd_cnt_d = '0;
        end else if (hs_rd) begin
            if (!awvalid_i) begin
                rd_cnt_d = '0;
            end else if (rd_cnt_q != CNT_MAX) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
        end
    end
`else
    assign tie_rd = last_wr_q;
`endif

    always_comb begin
        can_accept = !rst && !tag_fifo_afull_i && (!req_valid_q || req_ready_i);
        grant_rd   = arvalid_i && (!awvalid_i || tie_rd);
        grant_wr   = awvalid_i && (!arvalid_i || !tie_rd);
        hs_rd      = can_accept && grant_rd;
        hs_wr      = can_accept && grant_wr;
    end

    always_comb begin
        req_valid_d = req_valid_q;
        req_wr_d    = req_wr_q;
        req_id_d    = req_id_q;
        req_addr_d  = req_addr_q;
        last_wr_d   = last_wr_q;
        // A new handshake refills the slot in the same cycle it drains.
        if (hs_rd || hs_wr) begin
            req_valid_d = 1'b1;
            req_wr_d    = hs_wr;
            req_id_d    = hs_wr ? awid_i : arid_i;
            req_addr_d  = hs_wr ? awaddr_i : araddr_i;
            last_wr_d   = hs_wr;
        end else if (req_ready_i) begin
            req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_wr_q    <= 1'b0;
            req_id_q    <= '0;
            req_addr_q  <= '0;
            last_wr_q   <= 1'b1;
        end else begin
            req_valid_q <= req_valid_d;
            req_wr_q    <= req_wr_d;
            req_id_q    <= req_id_d;
            req_addr_q  <= req_addr_d;
            last_wr_q   <= last_wr_d;
        end
    end

    assign arready_o   = hs_rd;
    assign awready_o   = hs_wr;
    assign req_valid_o = req_valid_q;
    assign req_wr_o    = req_wr_q;
    assign req_id_o    = req_id_q;
    assign req_addr_o  = req_addr_q;

endmodule

// File: tb/tb_tag_req_arbiter.sv
// Scoreboard bench for tag_req_arbiter: accepted requests are queued and compared when the slot is consumed.
module tb_tag_req_arbiter;
    localparam int ID_W       = 16;
    localparam int ADDR_W     = 64;
    localparam int MAX_CONSEC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ID_W-1:0]   arid, awid;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic              arvalid, awvalid, arready, awready;
    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr, req_valid, req_ready, afull;

    always #5 clk = ~clk;

    tag_req_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .MAX_CONSEC(MAX_CONSEC)) dut (
        .clk(clk), .rst(rst),
        .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .req_id_o(req_id), .req_addr_o(req_addr), .req_wr_o(req_wr),
        .req_valid_o(req_valid), .req_ready_i(req_ready), .tag_fifo_afull_i(afull)
    );

    typedef struct packed {
        logic              wr;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state kept independently of the DUT.
    logic m_valid   = 1'b0;
    logic m_last_wr = 1'b1;
    int   m_cnt     = 0;
    logic [9:0] gbits;
    int   gcount;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One clock cycle: inputs are already set; checks readies/slot, updates the model, advances the sources.
    task automatic step();
        logic m_can, m_gr, m_gw, hs_r, hs_w;
        exp_t e;
        #1;
        m_can = !rst && !afull && (!m_valid || req_ready);
        if (arvalid && awvalid) begin
`ifdef TAG_ARB_RD_PRIO_EN
            m_gr = (m_cnt != MAX_CONSEC);
`else
            m_gr = m_last_wr;
`endif
            m_gw = !m_gr;
        end else begin
            m_gr = arvalid;
            m_gw = awvalid;
        end
        hs_r = m_can && m_gr;
        hs_w = m_can && m_gw;
        check_eq("arready", 64'(arready), 64'(hs_r));
        check_eq("awready", 64'(awready), 64'(hs_w));
        check_eq("req_valid", 64'(req_valid), 64'(m_valid));
        if (m_valid && req_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("req_wr", 64'(req_wr), 64'(e.wr));
                check_eq("req_id", 64'(req_id), 64'(e.id));
                check_eq("req_addr", req_addr, e.addr);
            end
        end
        if (rst) begin
            m_valid = 1'b0; m_last_wr = 1'b1; m_cnt = 0;
            exp_q.delete();
        end else if (hs_r || hs_w) begin
            e.wr   = hs_w;
            e.id   = hs_w ? awid : arid;
            e.addr = hs_w ? awaddr : araddr;
            exp_q.push_back(e);
            m_valid   = 1'b1;
            m_last_wr = hs_w;
            if (hs_w || !awvalid) m_cnt = 0;
            else if (m_cnt != MAX_CONSEC) m_cnt++;
            if (gcount < 10) gbits[gcount] = hs_w;
            gcount++;
        end else if (m_valid && req_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (hs_r) begin arid = arid + 1'b1; araddr = araddr + 64'd64; end
        if (hs_w) begin awid = awid + 1'b1; awaddr = awaddr + 64'd64; end
    endtask

    initial begin
        logic [9:0] exp_seq;
        rst = 1'b1; afull = 1'b0; req_ready = 1'b1;
        arid = '0; awid = 16'h100; araddr = 64'h1000; awaddr = 64'h8000;
        arvalid = 1'b1; awvalid = 1'b1;
        gbits = '0; gcount = 0;
        @(posedge clk);
        #1;

        // Reset held two cycles with both requests pending.
        step();
        step();
        check_eq("rst_id", 64'(req_id), 64'd0);
        check_eq("rst_addr", req_addr, 64'd0);
        check_eq("rst_wr", 64'(req_wr), 64'd0);
        rst = 1'b0;

        // Continuous tie for ten grants.
        gcount = 0;
        step();
        check_eq("first_tie_rd", 64'(req_wr), 64'd0);
        check_eq("first_tie_id", 64'(req_id), 64'd0);
        for (int i = 0; i < 9; i++) step();
`ifdef TAG_ARB_RD_PRIO_EN
        exp_seq = 10'b1000010000;
`else
        exp_seq = 10'b1010101010;
`endif
        check_eq("tie_sequence", 64'(gbits), 64'(exp_seq));
        check_eq("tie_grant_count", 64'(gcount), 64'd10);

        // Backpressure on a held read.
        arvalid = 1'b0; awvalid = 1'b0;
        step(); step();
        arvalid = 1'b1; araddr = 64'h64; req_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_hold_valid", 64'(req_valid), 64'd1);
            check_eq("bp_hold_addr", req_addr, 64'h64);
        end
        req_ready = 1'b1;
        step();
        check_eq("bp_next_valid", 64'(req_valid), 64'd1);
        check_eq("bp_next_addr", req_addr, 64'ha4);

        // Almost-full with a drained slot.
        arvalid = 1'b0;
        step(); step();
        afull = 1'b1; arvalid = 1'b1; awvalid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        afull = 1'b0;
        #1;
        check_eq("afull_release_accept", 64'(arready | awready), 64'd1);
        step();
        arvalid = 1'b0; awvalid = 1'b0;
        step(); step();

        // Reset while a request sits in the slot undelivered.
        arvalid = 1'b1; req_ready = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0; arvalid = 1'b0; req_ready = 1'b1;
        check_eq("rst_mid_drop", 64'(req_valid), 64'd0);
        for (int i = 0; i < 3; i++) step();

        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tag_req_arbiter.md
# tag_req_arbiter

Arbitrates between the AXI read-address (AR) and write-address (AW) channels of the DRAM cache front end and merges them into one tag-lookup request stream for the index extraction / tag-FIFO path. Accepts at most one request per cycle, holds it in a single registered output slot, and throttles both channels while the downstream tag FIFO reports almost-full. Default policy is round-robin; read priority with a write-starvation bound is available through a build option.

## Interface
Parameters:
- ID_W, 16, AXI ID width
- ADDR_W, 64, AXI address width
- MAX_CONSEC, 4, maximum consecutive read grants while a write is pending (read-priority build only); legal range ≥ 1

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- arid_i / araddr_i / arvalid_i  in  ID_W / ADDR_W / 1  AXI read-address request
- arready_o  out  1  AR accepted this cycle
- awid_i / awaddr_i / awvalid_i  in  ID_W / ADDR_W / 1  AXI write-address request
- awready_o  out  1  AW accepted this cycle
- req_id_o / req_addr_o  out  ID_W / ADDR_W  granted request ID and address
- req_wr_o  out  1  1 = write (AW) request, 0 = read (AR) request
- req_valid_o  out  1  output slot holds a request
- req_ready_i  in  1  downstream consumes the slot
- tag_fifo_afull_i  in  1  tag FIFO almost full; blocks new acceptance

## Operation
- can_accept = !rst && !tag_fifo_afull_i && (!req_valid_o || req_ready_i).
- Grant, combinational each cycle: only one valid → that channel; both valid → policy; neither → none. Grant is not locked across cycles; no handshake, no state change.
- arready_o = can_accept && grant_rd; awready_o = can_accept && grant_wr. Never both high.
- On a handshake the slot loads ID, address and req_wr_o, and req_valid_o = 1. Without a new handshake, req_ready_i && req_valid_o clears req_valid_o; otherwise the slot holds unchanged.
- Round-robin: last_wr records the type of the last accepted request; resets to 1 so reads win the first tie. A tie grants the type opposite to last_wr. last_wr updates on every handshake, including uncontested ones.
- Read-priority: see Configuration. rd_cnt is $clog2(MAX_CONSEC+1) bits wide and saturates at MAX_CONSEC.

## Timing
- Reset values: req_valid_o = 0, req_id_o = 0, req_addr_o = 0, req_wr_o = 0, arready_o = awready_o = 0, last_wr = 1, rd_cnt = 0.
- Latency: input handshake in cycle N → req_valid_o with that data in cycle N+1.
- Throughput: one request per cycle while req_ready_i = 1 and tag_fifo_afull_i = 0; the slot refills in the same cycle it drains.
- Slot full and req_ready_i = 0: both readies are 0 and the output stays stable (valid/data held).
- tag_fifo_afull_i = 1: both readies are 0 in that cycle; the occupied slot can still drain.
- rst asserted mid-operation: the slot is dropped (req_valid_o = 0 the next cycle) and both readies are 0 while rst = 1.

## Configuration
- TAG_ARB_RD_PRIO_EN defined: a tie grants read unless rd_cnt == MAX_CONSEC, in which case it grants write.
  - rd_cnt increments on a read grant while awvalid_i = 1.
  - rd_cnt clears on any write grant, and on a read grant with awvalid_i = 0.
  - last_wr is still maintained but is unused.
- TAG_ARB_RD_PRIO_EN undefined: pure round-robin, and rd_cnt is not built.

## Test plan
- Reset: rst = 1 for 2 cycles with both valids high → readies 0, req_valid_o = 0; after release, the first tie grants AR (arid 0), and req_wr_o = 0 the next cycle.
- Round-robin tie: AR and AW held valid, req_ready_i = 1, IDs incrementing → output alternates R, W, R, W at one request per cycle.
- Backpressure: req_ready_i = 0 after one accept, araddr 0x64 → req_valid_o held 1 with addr 0x64 and readies 0 until req_ready_i = 1; then the next request appears one cycle later.
- Almost-full: tag_fifo_afull_i = 1 for 3 cycles with the slot drained → no readies and req_valid_o = 0; the first accept occurs in the cycle afull drops.
- Read-priority (TAG_ARB_RD_PRIO_EN, MAX_CONSEC = 4): both channels continuously valid → sequence R, R, R, R, W, R, R, R, R, W.
- Reset mid-operation: rst pulses while req_valid_o = 1 and req_ready_i = 0 → req_valid_o = 0 the next cycle and the request is not delivered.
